// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared mode/alarm-state types and the modular add used for count updates
package alarm_clock_pkg;

  typedef enum logic [1:0] {MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM, MODE_RSVD} mode_t;
  typedef enum logic [1:0] {ALM_IDLE, ALM_RINGING, ALM_SNOOZE} alarm_state_t;

  // Sum is formed 17 bits wide so a modulus of 65536 still wraps correctly.
  function automatic logic [15:0] wrap_add(input logic [15:0] count, input logic [15:0] step,
                                           input logic [16:0] modulus);
    logic [16:0] w_sum;
    w_sum = {1'b0, count} + {1'b0, step};
    return (w_sum >= modulus) ? 16'(w_sum - modulus) : w_sum[15:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by CLK_DIV into a one-cycle tick strobe; hold parks the count at 0
module tick_prescaler #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] r_cnt;

  assign tick = !hold && (r_cnt == W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (hold || tick) ? '0 : r_cnt + 1'b1;

endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: time/alarm counts, button setting and alarm FSM with snooze.
// Define SET_BLINK_EN to blink the display enable while in a set mode.
module alarm_clock_core
  import alarm_clock_pkg::*;
#(
  parameter int CLK_DIV      = 50000000,
  parameter int WRAP         = 60000,
  parameter int STEP         = 1,
  parameter int SNOOZE_TICKS = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        inc_btn,
  input  logic        alarm_on,
  input  logic        snooze_btn,
  input  logic        stop_btn,
  output logic [15:0] value,
  output logic        enable,
  output logic        alarm_ring
);

  localparam logic [16:0] LP_WRAP = 17'(WRAP);
  localparam logic [15:0] LP_STEP = 16'(STEP);
  localparam int          SW      = $clog2(SNOOZE_TICKS + 1);

  mode_t        w_mode;
  alarm_state_t r_state;
  logic [15:0]  r_time, r_alarm, w_time_nxt, w_alarm_nxt;
  logic [SW-1:0] r_snz_cnt;
  logic         r_inc_q, r_snz_q, r_stop_q, r_ring;
  logic         w_run, w_set, w_tick, w_inc_e, w_snz_e, w_stop_e;

  assign w_mode   = mode_t'(mode);
  assign w_set    = (w_mode == MODE_SET_TIME) || (w_mode == MODE_SET_ALARM);
  assign w_run    = !w_set;
  assign w_inc_e  = inc_btn && !r_inc_q;
  assign w_snz_e  = snooze_btn && !r_snz_q;
  assign w_stop_e = stop_btn && !r_stop_q;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .hold (w_set),
    .tick (w_tick)
  );

  assign w_time_nxt  = w_tick ? wrap_add(r_time, 16'd1, LP_WRAP)
                     : (w_mode == MODE_SET_TIME && w_inc_e) ? wrap_add(r_time, LP_STEP, LP_WRAP)
                     : r_time;
  assign w_alarm_nxt = (w_mode == MODE_SET_ALARM && w_inc_e) ? wrap_add(r_alarm, LP_STEP, LP_WRAP)
                     : r_alarm;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_time   <= '0;
      r_alarm  <= '0;
      r_inc_q  <= 1'b0;
      r_snz_q  <= 1'b0;
      r_stop_q <= 1'b0;
    end else begin
      r_time   <= w_time_nxt;
      r_alarm  <= w_alarm_nxt;
      r_inc_q  <= inc_btn;
      r_snz_q  <= snooze_btn;
      r_stop_q <= stop_btn;
    end

  // Stop conditions are tested before snooze so a simultaneous stop+snooze lands in IDLE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= ALM_IDLE;
      r_snz_cnt <= '0;
      r_ring    <= 1'b0;
    end else begin
      case (r_state)
        ALM_IDLE:
          if (w_run && alarm_on && w_tick && w_time_nxt == r_alarm) begin
            r_state <= ALM_RINGING;
            r_ring  <= 1'b1;
          end
        ALM_RINGING:
          if (w_stop_e || !alarm_on || !w_run) begin
            r_state <= ALM_IDLE;
            r_ring  <= 1'b0;
          end else if (w_snz_e) begin
            r_state   <= ALM_SNOOZE;
            r_snz_cnt <= SW'(SNOOZE_TICKS);
            r_ring    <= 1'b0;
          end
        ALM_SNOOZE:
          if (w_stop_e || !alarm_on || !w_run) begin
            r_state <= ALM_IDLE;
            r_ring  <= 1'b0;
          end else if (w_tick) begin
            if (r_snz_cnt == SW'(1)) begin
              r_state <= ALM_RINGING;
              r_ring  <= 1'b1;
            end else r_snz_cnt <= r_snz_cnt - 1'b1;
          end
        default: begin
          r_state <= ALM_IDLE;
          r_ring  <= 1'b0;
        end
      endcase
    end

  assign value      = (w_mode == MODE_SET_ALARM) ? r_alarm : r_time;
  assign alarm_ring = r_ring;

`ifdef SET_BLINK_EN
  localparam int BW = $clog2(CLK_DIV);
  logic [BW-1:0] r_blink;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_blink <= '0;
    else r_blink <= (r_blink == BW'(CLK_DIV - 1)) ? '0 : r_blink + 1'b1;
  assign enable = !(w_set && r_blink >= BW'(CLK_DIV / 2));
`else
  assign enable = 1'b1;
`endif

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed checks of counting, setting, alarm/snooze and display enable
module tb_alarm_clock_core;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        inc_btn = 1'b0, alarm_on = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
  logic [15:0] value;
  logic        enable, alarm_ring;
  int          checks = 0, errors = 0;
  logic [31:0] r_cyc;

  alarm_clock_core #(.CLK_DIV(4), .WRAP(20), .STEP(1), .SNOOZE_TICKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .inc_btn   (inc_btn),
    .alarm_on  (alarm_on),
    .snooze_btn(snooze_btn),
    .stop_btn  (stop_btn),
    .value     (value),
    .enable    (enable),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) r_cyc <= 0;
    else r_cyc <= r_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc();
    inc_btn = 1'b1;
    wait_clk(2);
    inc_btn = 1'b0;
    wait_clk(2);
  endtask

  task automatic do_reset();
    {inc_btn, alarm_on, snooze_btn, stop_btn} = '0;
    mode  = 2'd0;
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
  endtask

  task automatic set_alarm(input int n);
    mode = 2'd2;
    for (int i = 0; i < n; i++) pulse_inc();
  endtask

  task automatic ring_seen(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_clk(1);
      if (alarm_ring) seen = 1'b1;
    end
  endtask

  task automatic arm_and_ring();
    do_reset();
    set_alarm(3);
    alarm_on = 1'b1;
    mode     = 2'd0;
    wait_clk(12);
    chk("ring_armed", alarm_ring, 1);
  endtask

  function automatic logic exp_enable(input logic [1:0] m, input logic [31:0] c);
`ifdef SET_BLINK_EN
    return !((m == 2'd1 || m == 2'd2) && (c % 4) >= 2);
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    do_reset();
    chk("rst_value", value, 0);
    chk("rst_ring", alarm_ring, 0);
    chk("rst_enable", enable, 1);
    // RUN: one count per 4 cycles, wrapping at 20
    for (int k = 1; k <= 21; k++) begin
      wait_clk(4);
      chk($sformatf("run_count_%0d", k), value, 32'(k % 20));
    end
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_value", value, 0);
    chk("async_rst_ring", alarm_ring, 0);
    wait_clk(1);
    rst_n = 1'b1;

    mode = 2'd1;
    for (int i = 0; i < 25; i++) pulse_inc();
    chk("set_time_25", value, 5);
    wait_clk(20);
    chk("set_time_no_tick", value, 5);
    inc_btn = 1'b1;
    wait_clk(10);
    inc_btn = 1'b0;
    wait_clk(2);
    chk("inc_held_once", value, 6);

    mode = 2'd2;
    #1;
    chk("alarm_view_0", value, 0);
    for (int i = 0; i < 7; i++) pulse_inc();
    chk("alarm_view_7", value, 7);
    mode = 2'd0;
    #1;
    chk("run_view_time", value, 6);
    wait_clk(1);
    set_alarm(12);
    chk("alarm_19", value, 19);
    pulse_inc();
    chk("alarm_wrap", value, 0);

    do_reset();
    set_alarm(3);
    chk("alarm_set_3", value, 3);
    alarm_on = 1'b1;
    mode     = 2'd0;
    wait_clk(11);
    chk("pre_match_value", value, 2);
    chk("pre_match_ring", alarm_ring, 0);
    wait_clk(1);
    chk("match_value", value, 3);
    chk("match_ring", alarm_ring, 1);
    stop_btn = 1'b1;
    #1;
    chk("stop_pending_ring", alarm_ring, 1);
    wait_clk(1);
    stop_btn = 1'b0;
    chk("stop_ring", alarm_ring, 0);

    do_reset();
    set_alarm(3);
    mode = 2'd0;
    ring_seen(16, seen);
    chk("alarm_off_no_ring", seen, 0);
    chk("alarm_off_value", value, 4);

    arm_and_ring();
    snooze_btn = 1'b1;
    wait_clk(1);
    snooze_btn = 1'b0;
    chk("snooze_ring_low", alarm_ring, 0);
    wait_clk(10);
    chk("snooze_before_rering", alarm_ring, 0);
    wait_clk(1);
    chk("snooze_rering", alarm_ring, 1);
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    wait_clk(1);
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    chk("stop_snooze_ring", alarm_ring, 0);
    ring_seen(16, seen);
    chk("stop_wins_no_rering", seen, 0);

    arm_and_ring();
    snooze_btn = 1'b1;
    wait_clk(1);
    snooze_btn = 1'b0;
    wait_clk(2);
    mode = 2'd1;
    wait_clk(1);
    mode = 2'd0;
    ring_seen(16, seen);
    chk("mode_exit_snooze", seen, 0);

    // Display enable across all three modes
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      for (int i = 0; i < 8; i++) begin
        wait_clk(1);
        chk($sformatf("enable_m%0d_%0d", m, i), enable, exp_enable(mode, r_cyc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
